// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: trig pulse, echo width timing and width-to-PWM-compare mapping.
// Optional macro RANGER_AVG_EN maps the mean of the last four echo widths instead of the raw one.
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3_802_000,
  parameter int unsigned PERIOD_CYCLES  = 6_000_000,
  parameter int unsigned BAND1          = 475_250,
  parameter int unsigned BAND2          = 950_500,
  parameter int unsigned BAND3          = 1_425_750,
  parameter int unsigned PWM_FULL       = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        range_valid,
  output logic        timeout,
  output logic [21:0] echo_cycles,
  output logic [18:0] pulse_width
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [22:0] TRIG_LAST   = 23'(TRIG_CYCLES - 1);
  localparam logic [22:0] WAIT_LAST   = 23'(TRIG_CYCLES + TIMEOUT_CYCLES - 1);
  localparam logic [22:0] PERIOD_LAST = 23'(PERIOD_CYCLES - 1);
  localparam logic [21:0] TIMEOUT_W   = 22'(TIMEOUT_CYCLES);
  localparam logic [21:0] BAND1_W     = 22'(BAND1);
  localparam logic [21:0] BAND2_W     = 22'(BAND2);
  localparam logic [21:0] BAND3_W     = 22'(BAND3);
  localparam logic [18:0] PW_STEP1    = 19'(PWM_FULL / 4);
  localparam logic [18:0] PW_STEP2    = 19'(PWM_FULL / 2);
  localparam logic [18:0] PW_STEP3    = 19'((PWM_FULL * 3) / 4);
  localparam logic [18:0] PW_STEP4    = 19'(PWM_FULL);

  state_t      state_r, state_next;
  logic [22:0] cyc_r, cyc_next;
  logic [21:0] width_r, width_next;
  logic        echo_meta_r, echo_sync_r, echo_dly_r;
  logic        rise_s, fall_s;
  logic        to_s, done_s;
  logic [21:0] sample_s, map_in_s;
  logic [18:0] pw_s;
  logic        trig_r, busy_r, valid_r, timeout_r;
  logic [21:0] echo_cycles_r;
  logic [18:0] pulse_width_r;

  function automatic logic [18:0] map_width(input logic [21:0] w);
    logic [18:0] pw;
    if (w == 22'd0) begin
      pw = 19'd0;
    end else if (w <= BAND1_W) begin
      pw = PW_STEP1;
    end else if (w <= BAND2_W) begin
      pw = PW_STEP2;
    end else if (w <= BAND3_W) begin
      pw = PW_STEP3;
    end else begin
      pw = PW_STEP4;
    end
    return pw;
  endfunction

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
      echo_dly_r  <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      echo_dly_r  <= echo_sync_r;
    end
  end

  assign rise_s = echo_sync_r & ~echo_dly_r;
  assign fall_s = ~echo_sync_r & echo_dly_r;

  // Next-state logic; a fall seen in the same cycle as the width limit wins over timeout.
  always_comb begin
    state_next = state_r;
    cyc_next   = cyc_r + 23'd1;
    width_next = width_r;
    sample_s   = width_r;
    to_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cyc_r == PERIOD_LAST) begin
          state_next = S_TRIG;
          cyc_next   = 23'd0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_TRIG: begin
        if (cyc_r == TRIG_LAST) begin
          state_next = S_WAIT_RISE;
        end else begin
          state_next = S_TRIG;
        end
      end
      S_WAIT_RISE: begin
        if (rise_s) begin
          state_next = S_MEASURE;
          width_next = 22'd1;
        end else if (cyc_r == WAIT_LAST) begin
          state_next = S_DONE;
          to_s       = 1'b1;
          sample_s   = TIMEOUT_W;
        end else begin
          state_next = S_WAIT_RISE;
        end
      end
      S_MEASURE: begin
        if (fall_s) begin
          state_next = S_DONE;
        end else if (width_r == TIMEOUT_W) begin
          state_next = S_DONE;
          to_s       = 1'b1;
          sample_s   = TIMEOUT_W;
        end else begin
          width_next = width_r + 22'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign done_s = (state_next == S_DONE);

  // State, cycle and width registers; cyc preset so TRIG follows reset release directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cyc_r   <= PERIOD_LAST;
      width_r <= 22'd0;
    end else begin
      state_r <= state_next;
      cyc_r   <= cyc_next;
      width_r <= width_next;
    end
  end

`ifdef RANGER_AVG_EN
  // The oldest of the four entries drops out as the new one arrives, so three are stored.
  logic [2:0][21:0] hist_r;
  logic             hist_full_r;
  logic [23:0]      sum_s;

  always_comb begin
    sum_s = {sample_s, 2'b00};
    if (hist_full_r) begin
      sum_s = {2'b00, sample_s} + {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]};
    end else begin
      sum_s = {sample_s, 2'b00};
    end
  end

  assign map_in_s = sum_s[23:2];

  // History of previous samples; the first sample after reset fills every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r      <= '0;
      hist_full_r <= 1'b0;
    end else if (done_s) begin
      hist_full_r <= 1'b1;
      if (hist_full_r) begin
        hist_r <= {hist_r[1:0], sample_s};
      end else begin
        hist_r <= {3{sample_s}};
      end
    end
  end
`else
  assign map_in_s = sample_s;
`endif

  assign pw_s = to_s ? PW_STEP4 : map_width(map_in_s);

  // Registered outputs, taken from the next state so strobes coincide with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_r        <= 1'b0;
      busy_r        <= 1'b0;
      valid_r       <= 1'b0;
      timeout_r     <= 1'b0;
      echo_cycles_r <= 22'd0;
      pulse_width_r <= 19'd0;
    end else begin
      trig_r    <= (state_next == S_TRIG);
      busy_r    <= (state_next != S_IDLE);
      valid_r   <= done_s;
      timeout_r <= done_s & to_s;
      if (done_s) begin
        echo_cycles_r <= sample_s;
        pulse_width_r <= pw_s;
      end
    end
  end

  assign trig        = trig_r;
  assign busy        = busy_r;
  assign range_valid = valid_r;
  assign timeout     = timeout_r;
  assign echo_cycles = echo_cycles_r;
  assign pulse_width = pulse_width_r;

endmodule
